frame_feeder: RTL and testbench
===============================

FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 SHALL have parameter H_PIX, default 640, pixels per line (2..4096).
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame (1..4096).
REQ-003 SHALL have parameter SOF_WORD, default 16'hA5A5, start-of-frame header word.
REQ-004 SHALL have port clk  input  1  sole clock; the same clock as the FIFO write clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle frame request.
REQ-007 SHALL have port pattern_sel  input  2  pattern code, sampled on an accepted start.
REQ-008 SHALL have port almost_full  input  1  FIFO back-pressure flag.
REQ-009 SHALL have port din  output  16  FIFO write data.
REQ-010 SHALL have port wr_en  output  1  FIFO write strobe.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-013 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, PIX and DONE.
REQ-015 SHALL move IDLE->HDR on start=1 and latch pattern_sel at that edge; start SHALL be ignored in every other state.
REQ-016 SHALL, in HDR, issue SOF_WORD once and then move to PIX.
REQ-017 SHALL, in PIX, issue H_PIX*V_LINES pixel words in raster order: x counts 0..H_PIX-1, and y increments when x wraps.
REQ-018 SHALL move PIX->DONE after the word with x=H_PIX-1 and y=V_LINES-1 is issued.
REQ-019 SHALL, in DONE, pulse frame_done for one cycle, increment frame_cnt modulo 2^16 (16'hFFFF wraps to 0), and return to IDLE on the next cycle.
REQ-020 SHALL register din and wr_en; a word is issued (wr_en=1 in cycle n+1) only if the FSM is in HDR or PIX and almost_full=0 at clock edge n.
REQ-021 SHALL advance x, y and the FSM only on cycles in which a word is issued.
REQ-022 SHALL, when almost_full=1, drive wr_en=0 and hold x, y and the state, so no word is lost or duplicated.
REQ-023 SHALL NOT constrain din while wr_en=0.
REQ-024 SHALL generate pixel values per latched pattern:
- 0: {x[15:0]}
- 1: {y[15:0]}
- 2: 16'hFFFF if x[3]^y[3], else 16'h0000
- 3: {frame_cnt[7:0], x[7:0]}
REQ-025 SHALL drive busy=1 in HDR, PIX and DONE, and busy=0 in IDLE.
REQ-026 SHALL, when start coincides with the DONE cycle, ignore that start; the next start is accepted in IDLE.
REQ-027 SHALL keep total words per frame exactly 1+H_PIX*V_LINES regardless of the back-pressure pattern.

Reset
REQ-028 SHALL, on rst=1, asynchronously force:
- state=IDLE
- x=0, y=0
- din=16'h0000, wr_en=0
- busy=0, frame_done=0
- frame_cnt=0
- latched pattern=0
REQ-029 SHALL, on rst asserted mid-frame, abandon the frame without a frame_done pulse and without incrementing frame_cnt.
REQ-030 SHALL accept start on the first clock edge after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding, the pattern codes (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_FCNT) and the SOF_WORD default in shared package feeder_pkg.
REQ-032 SHALL implement pixel value generation as one sub-module, feeder_pattern: purely combinational, inputs x, y, frame_cnt and pattern, output a 16-bit pixel.
REQ-033 SHALL size the x and y counters at 12 bits, zero-extended to 16 bits for the patterns.

Verification (H_PIX=4, V_LINES=2 unless noted)
REQ-034 SHALL cover: start, pattern 0, almost_full=0 -> wr_en high for 9 consecutive cycles carrying A5A5,0,1,2,3,0,1,2,3; frame_done pulses once; frame_cnt=1.
REQ-035 SHALL cover: pattern 1 with almost_full toggling every 2 cycles -> data sequence A5A5,0,0,0,0,1,1,1,1 exactly, and no write in any cycle following an almost_full=1 edge.
REQ-036 SHALL cover: H_PIX=16, pattern 2 -> x=0..7 gives 0000, x=8..15 gives FFFF on line 0, inverted pattern on line 8 when V_LINES>=9.
REQ-037 SHALL cover: rst pulsed after the 5th write -> wr_en=0 and busy=0 immediately, frame_cnt stays 0; a new start yields a full 9-word frame.
REQ-038 SHALL cover: start repeated while busy and on the DONE cycle -> exactly one frame produced, frame_cnt=1.
REQ-039 SHALL cover: frame_cnt preloaded via 65536 frames (or forced to 16'hFFFF), pattern 3 -> pixels FF00..FF03, then frame_cnt wraps to 0000.

Source files
------------

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared state encoding, pattern codes and defaults for frame_feeder
package feeder_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2,
    DONE = 2'd3
  } feeder_state_t;

  // Pixel pattern codes, latched when a frame is accepted
  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FCNT  = 2'd3
  } pattern_t;

  // Raster coordinate width; coordinates are zero-extended to 16 bits in patterns
  localparam int CNT_W = 12;

  // Start-of-frame header word written ahead of every frame
  localparam logic [15:0] SOF_DEFAULT = 16'hA5A5;

endpackage

// File: rtl/feeder_pattern.sv
// rtl/feeder_pattern.sv - combinational pixel value generator
module feeder_pattern
  import feeder_pkg::*;
(
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [15:0]      frame_cnt,
  input  pattern_t         pattern,
  output logic [15:0]      pixel
);

  logic [15:0] x_ext;
  logic [15:0] y_ext;
  logic        unused_fcnt_hi;

  assign x_ext = {{(16-CNT_W){1'b0}}, x};
  assign y_ext = {{(16-CNT_W){1'b0}}, y};

  // Only the low byte of the frame counter is shown in the counter pattern
  assign unused_fcnt_hi = ^frame_cnt[15:8];

  // Select the pixel value for the latched pattern at raster position (x, y)
  always_comb begin
    pixel = 16'h0000;
    case (pattern)
      PAT_HRAMP: pixel = x_ext;
      PAT_VRAMP: pixel = y_ext;
      PAT_CHECK: pixel = (x_ext[3] ^ y_ext[3]) ? 16'hFFFF : 16'h0000;
      PAT_FCNT:  pixel = {frame_cnt[7:0], x_ext[7:0]};
      default:   pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/frame_feeder.sv
// rtl/frame_feeder.sv - writes a header word plus one raster frame of pixels into a FIFO
module frame_feeder
  import feeder_pkg::*;
#(
  parameter int          H_PIX    = 640,
  parameter int          V_LINES  = 480,
  parameter logic [15:0] SOF_WORD = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic        almost_full,
  output logic [15:0] din,
  output logic        wr_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_PIX - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_LINES - 1);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  pattern_t         pat_q, pat_d;
  logic [15:0]      din_q, din_d;
  logic             wr_en_q, wr_en_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      pixel;

  // Pixel value for the current raster position; frame_cnt_q is the count of frames already finished
  feeder_pattern u_pattern (
    .x         (x_q),
    .y         (y_q),
    .frame_cnt (frame_cnt_q),
    .pattern   (pat_q),
    .pixel     (pixel)
  );

  // Next-state logic: a word is only issued, and position only advances, when the FIFO has room
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pat_d       = pat_q;
    din_d       = din_q;
    wr_en_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          pat_d   = pattern_t'(pattern_sel);
        end
      end

      HDR: begin
        if (!almost_full) begin
          wr_en_d = 1'b1;
          din_d   = SOF_WORD;
          x_d     = '0;
          y_d     = '0;
          state_d = PIX;
        end
      end

      PIX: begin
        if (!almost_full) begin
          wr_en_d = 1'b1;
          din_d   = pixel;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      DONE: begin
        // Any start seen here is dropped; the next one is taken from IDLE
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight without counting it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pat_q       <= PAT_HRAMP;
      din_q       <= 16'h0000;
      wr_en_q     <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pat_q       <= pat_d;
      din_q       <= din_d;
      wr_en_q     <= wr_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign din        = din_q;
  assign wr_en      = wr_en_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_feeder.sv
// tb/tb_frame_feeder.sv - randomized self-checking bench for frame_feeder
module tb_frame_feeder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, almost_full;
  logic [1:0]  pattern_sel;
  logic [15:0] din, frame_cnt;
  logic        wr_en, busy, frame_done;

  logic        start_b, almost_full_b;
  logic [1:0]  pattern_sel_b;
  logic [15:0] din_b, frame_cnt_b;
  logic        wr_en_b, busy_b, frame_done_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_b   = 0;
  int viol     = 0;

  logic [15:0] obs_q[$];
  int          obs_cyc[$];
  logic [15:0] obs_b[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  frame_feeder #(.H_PIX(4), .V_LINES(2), .SOF_WORD(16'hA5A5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pattern_sel (pattern_sel),
    .almost_full (almost_full),
    .din         (din),
    .wr_en       (wr_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  frame_feeder #(.H_PIX(16), .V_LINES(9), .SOF_WORD(16'hA5A5)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .pattern_sel (pattern_sel_b),
    .almost_full (almost_full_b),
    .din         (din_b),
    .wr_en       (wr_en_b),
    .busy        (busy_b),
    .frame_done  (frame_done_b),
    .frame_cnt   (frame_cnt_b)
  );

  // Monitor: capture back-pressure at the edge, then outputs 1 time unit later
  always @(posedge clk) begin
    logic af_e;
    af_e = almost_full;
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      obs_q.push_back(din);
      obs_cyc.push_back(cyc);
      if (af_e) viol++;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (wr_en_b === 1'b1) obs_b.push_back(din_b);
    if (frame_done_b === 1'b1) done_b++;
  end

  function automatic logic [15:0] model_pix(int pat, int x, int y, int fc);
    case (pat)
      0:       return 16'(x);
      1:       return 16'(y);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
      default: return 16'(((fc % 256) * 256) + (x % 256));
    endcase
  endfunction

  function automatic void build_expect(int pat, int h, int v, int fc);
    exp_q.delete();
    exp_q.push_back(16'hA5A5);
    for (int yy = 0; yy < v; yy++)
      for (int xx = 0; xx < h; xx++)
        exp_q.push_back(model_pix(pat, xx, yy, fc));
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    obs_b.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0; almost_full = 1'b0; pattern_sel = 2'd0;
    start_b = 1'b0; almost_full_b = 1'b0; pattern_sel_b = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: no back-pressure, 1: toggle every 2 cycles, 2: random
  task automatic drive_frame(input logic [1:0] pat, input int mode, output bit timed_out);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    start = 1'b1;
    pattern_sel = pat;
    @(negedge clk);
    start = 1'b0;
    pattern_sel = 2'($urandom);
    while (done_cnt == d0 && k < 5000) begin
      case (mode)
        0:       almost_full = 1'b0;
        1:       almost_full = ((k / 2) % 2) == 1;
        default: almost_full = ($urandom % 10) < 4;
      endcase
      @(negedge clk);
      k++;
    end
    almost_full = 1'b0;
    timed_out = (done_cnt == d0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (frame_cnt !== 16'h0000) $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); else n_pass++;
    n_checks++; if (din !== 16'h0000) $display("FAIL reset_din got %h want 0000", din); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    int d0;
    do_reset();
    clear_obs();
    d0 = done_cnt;
    drive_frame(2'd0, 0, to);
    repeat (5) @(negedge clk);
    build_expect(0, 4, 2, 0);
    n_checks++; if (to) $display("FAIL basic_timeout got timeout want frame_done"); else n_pass++;
    n_checks++; if (obs_q.size() != 9) $display("FAIL basic_count got %0d want 9", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++;
    if (obs_cyc.size() == 9 && obs_cyc[8] - obs_cyc[0] == 8) n_pass++;
    else $display("FAIL basic_consecutive got span %0d want 8", obs_cyc.size() == 9 ? obs_cyc[8] - obs_cyc[0] : -1);
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %h want 0001", frame_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    clear_obs();
    viol = 0;
    drive_frame(2'd1, 1, to);
    build_expect(1, 4, 2, 0);
    n_checks++; if (to) $display("FAIL bp_timeout got timeout want frame_done"); else n_pass++;
    n_checks++; if (obs_q.size() != 9) $display("FAIL bp_count got %0d want 9", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bp_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (viol != 0) $display("FAIL bp_write_under_af got %0d want 0", viol); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd1) $display("FAIL bp_frame_cnt got %h want 0001", frame_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    int pat;
    int exp_fc;
    do_reset();
    viol = 0;
    exp_fc = 0;
    for (int f = 0; f < 6; f++) begin
      pat = int'($urandom % 4);
      clear_obs();
      drive_frame(2'(pat), 2, to);
      build_expect(pat, 4, 2, exp_fc);
      exp_fc++;
      n_checks++; if (to) $display("FAIL rnd_timeout frame %0d got timeout want frame_done", f); else n_pass++;
      n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count frame %0d got %0d want %0d", f, obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rnd_word f%0d p%0d [%0d] got %h want %h", f, pat, i, obs_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (frame_cnt !== 16'(exp_fc)) $display("FAIL rnd_frame_cnt got %h want %h", frame_cnt, 16'(exp_fc)); else n_pass++;
    end
    n_checks++; if (viol != 0) $display("FAIL rnd_write_under_af got %0d want 0", viol); else n_pass++;
  endtask

  task automatic test_checker();
    int d0;
    int k;
    do_reset();
    clear_obs();
    d0 = done_b;
    start_b = 1'b1;
    pattern_sel_b = 2'd2;
    @(negedge clk);
    start_b = 1'b0;
    pattern_sel_b = 2'd0;
    k = 0;
    while (done_b == d0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    build_expect(2, 16, 9, 0);
    n_checks++; if (done_b == d0) $display("FAIL chk_timeout got timeout want frame_done"); else n_pass++;
    n_checks++; if (obs_b.size() != 145) $display("FAIL chk_count got %0d want 145", obs_b.size()); else n_pass++;
    for (int i = 0; i < obs_b.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_b[i] !== exp_q[i]) $display("FAIL chk_word[%0d] got %h want %h", i, obs_b[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int d0;
    do_reset();
    clear_obs();
    start = 1'b1;
    pattern_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (obs_q.size() < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (obs_q.size() != 5) $display("FAIL mid_reach5 got %0d want 5", obs_q.size()); else n_pass++;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en got %b want 0", wr_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd0) $display("FAIL mid_frame_cnt got %h want 0000", frame_cnt); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (done_cnt != d0) $display("FAIL mid_no_done got %0d want %0d", done_cnt, d0); else n_pass++;
    clear_obs();
    rst = 1'b0;
    start = 1'b1;
    pattern_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_start_after_rst got %b want 1", busy); else n_pass++;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    build_expect(0, 4, 2, 0);
    n_checks++; if (obs_q.size() != 9) $display("FAIL mid_refill_count got %0d want 9", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL mid_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (frame_cnt !== 16'd1) $display("FAIL mid_frame_cnt_after got %h want 0001", frame_cnt); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int d0;
    int k;
    do_reset();
    clear_obs();
    d0 = done_cnt;
    start = 1'b1;
    pattern_sel = 2'd0;
    k = 0;
    @(negedge clk);
    while (done_cnt == d0 && k < 200) begin
      pattern_sel = 2'($urandom);
      @(negedge clk);
      k++;
    end
    // start is still high across the DONE->IDLE edge here
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    build_expect(0, 4, 2, 0);
    n_checks++; if (obs_q.size() != 9) $display("FAIL ign_count got %0d want 9", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ign_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL ign_done_pulses got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd1) $display("FAIL ign_frame_cnt got %h want 0001", frame_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    n_checks++; if (frame_cnt !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", frame_cnt); else n_pass++;
    clear_obs();
    drive_frame(2'd3, 0, to);
    build_expect(3, 4, 2, 16'hFFFF);
    n_checks++; if (to) $display("FAIL wrap_timeout got timeout want frame_done"); else n_pass++;
    n_checks++; if (obs_q.size() != 9) $display("FAIL wrap_count got %0d want 9", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (frame_cnt !== 16'h0000) $display("FAIL wrap_frame_cnt got %h want 0000", frame_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; almost_full = 1'b0; pattern_sel = 2'd0;
    start_b = 1'b0; almost_full_b = 1'b0; pattern_sel_b = 2'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_checker();
    test_reset_mid();
    test_start_ignored();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
